// File: rtl/apb_mem_slv.sv
// APB4 completer backed by on-chip word storage: programmable wait states,
// byte-strobe writes, PSLVERR on out-of-range or misaligned accesses.
module apb_mem_slv #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int DEPTH           = 256,
  parameter int WAIT_CYCLES     = 0,
  parameter int ERR_ON_MISALIGN = 1
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic [ADDR_WIDTH-1:0]   PADDR,
  input  logic                    PWRITE,
  input  logic [DATA_WIDTH-1:0]   PWDATA,
  input  logic [DATA_WIDTH/8-1:0] PSTRB,
  output logic                    PREADY,
  output logic [DATA_WIDTH-1:0]   PRDATA,
  output logic                    PSLVERR
);

  localparam int unsigned BYTES = DATA_WIDTH / 8;
  localparam int unsigned LSB   = $clog2(BYTES);
  localparam int unsigned IDXW  = $clog2(DEPTH);
  localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_e;

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic [IDXW-1:0]       idx_q;
  logic                  write_q;
  logic                  err_q;
  logic                  pready_q;
  logic                  pslverr_q;
  logic [DATA_WIDTH-1:0] prdata_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  setup_d;
  logic                  access_d;
  logic [ADDR_WIDTH-1:0] hi_bits_d;
  logic [IDXW-1:0]       idx_d;
  logic                  err_d;
  logic [IDXW-1:0]       rd_idx_d;
  logic                  rd_write_d;
  logic                  rd_err_d;
  logic [DATA_WIDTH-1:0] rd_data_d;
  logic                  mem_we_d;

  // Read data is fetched on the edge entering RESP: from the live bus when
  // coming straight out of IDLE, otherwise from the captured setup.
  always_comb begin
    setup_d    = PSEL & ~PENABLE;
    access_d   = PSEL & PENABLE;
    hi_bits_d  = PADDR >> (LSB + IDXW);
    idx_d      = IDXW'(PADDR >> LSB);
    err_d      = (hi_bits_d != '0) |
                 ((ERR_ON_MISALIGN != 0) & ((PADDR & LOW_MASK) != '0));
    rd_idx_d   = (state_q == ST_IDLE) ? idx_d  : idx_q;
    rd_write_d = (state_q == ST_IDLE) ? PWRITE : write_q;
    rd_err_d   = (state_q == ST_IDLE) ? err_d  : err_q;
    rd_data_d  = (rd_write_d | rd_err_d) ? '0 : mem_q[rd_idx_d];
    mem_we_d   = (state_q == ST_RESP) & access_d & write_q & ~err_q;
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (setup_d) begin
            idx_q   <= idx_d;
            write_q <= PWRITE;
            err_q   <= err_d;
            cnt_q   <= WAIT_INIT;
            if (WAIT_INIT == 4'd0) begin
              state_q   <= ST_RESP;
              pready_q  <= 1'b1;
              pslverr_q <= err_d;
              prdata_q  <= rd_data_d;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (!access_d) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              state_q   <= ST_RESP;
              pready_q  <= 1'b1;
              pslverr_q <= err_q;
              prdata_q  <= rd_data_d;
            end
          end
        end
        ST_RESP: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Storage is deliberately unreset; commits only on a completing RESP cycle.
  always_ff @(posedge PCLK) begin
    if (mem_we_d) begin
      for (int unsigned i = 0; i < BYTES; i++) begin
        if (PSTRB[i]) mem_q[idx_q][8*i +: 8] <= PWDATA[8*i +: 8];
      end
    end
  end

  assign PREADY  = pready_q;
  assign PSLVERR = pslverr_q;
  assign PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_mem_slv.sv
// Bench for apb_mem_slv: five parameterisations on a shared APB bus, table
// vectors, abort/reset sequences and random back-to-back traffic.
module tb_apb_mem_slv;

  logic        PCLK;
  logic        rst_n;
  logic [4:0]  psel;
  logic        penable;
  logic [31:0] paddr;
  logic        pwrite;
  logic [63:0] pwdata;
  logic [7:0]  pstrb;
  wire  [4:0]  pready;
  wire  [4:0]  pslverr;
  wire  [31:0] prd0, prd1, prd2;
  wire  [7:0]  prd3;
  wire  [63:0] prd4;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int          k;
    logic        wr;
    logic [31:0] addr;
    logic [63:0] wd;
    logic [7:0]  st;
    logic [63:0] rd;
    logic        err;
    int          waits;
  } vec_t;

  typedef struct {
    int          k;
    logic [63:0] rd;
    logic        err;
    int          waits;
  } sb_t;

  vec_t        tbl[$];
  sb_t         sb[$];
  logic [63:0] mdl [5][256];

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  apb_mem_slv #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .WAIT_CYCLES(0), .ERR_ON_MISALIGN(1)) u_w0 (
    .PCLK(PCLK), .PRESETn(rst_n), .PSEL(psel[0]), .PENABLE(penable), .PADDR(paddr), .PWRITE(pwrite),
    .PWDATA(pwdata[31:0]), .PSTRB(pstrb[3:0]), .PREADY(pready[0]), .PRDATA(prd0), .PSLVERR(pslverr[0]));
  apb_mem_slv #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .WAIT_CYCLES(3), .ERR_ON_MISALIGN(0)) u_w3 (
    .PCLK(PCLK), .PRESETn(rst_n), .PSEL(psel[1]), .PENABLE(penable), .PADDR(paddr), .PWRITE(pwrite),
    .PWDATA(pwdata[31:0]), .PSTRB(pstrb[3:0]), .PREADY(pready[1]), .PRDATA(prd1), .PSLVERR(pslverr[1]));
  apb_mem_slv #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH(256), .WAIT_CYCLES(4), .ERR_ON_MISALIGN(1)) u_w4 (
    .PCLK(PCLK), .PRESETn(rst_n), .PSEL(psel[2]), .PENABLE(penable), .PADDR(paddr), .PWRITE(pwrite),
    .PWDATA(pwdata[31:0]), .PSTRB(pstrb[3:0]), .PREADY(pready[2]), .PRDATA(prd2), .PSLVERR(pslverr[2]));
  apb_mem_slv #(.ADDR_WIDTH(32), .DATA_WIDTH(8), .DEPTH(256), .WAIT_CYCLES(1), .ERR_ON_MISALIGN(1)) u_d8 (
    .PCLK(PCLK), .PRESETn(rst_n), .PSEL(psel[3]), .PENABLE(penable), .PADDR(paddr), .PWRITE(pwrite),
    .PWDATA(pwdata[7:0]), .PSTRB(pstrb[0:0]), .PREADY(pready[3]), .PRDATA(prd3), .PSLVERR(pslverr[3]));
  apb_mem_slv #(.ADDR_WIDTH(32), .DATA_WIDTH(64), .DEPTH(256), .WAIT_CYCLES(2), .ERR_ON_MISALIGN(1)) u_d64 (
    .PCLK(PCLK), .PRESETn(rst_n), .PSEL(psel[4]), .PENABLE(penable), .PADDR(paddr), .PWRITE(pwrite),
    .PWDATA(pwdata), .PSTRB(pstrb), .PREADY(pready[4]), .PRDATA(prd4), .PSLVERR(pslverr[4]));

  function automatic logic [63:0] prd(input int k);
    case (k)
      0:       return 64'(prd0);
      1:       return 64'(prd1);
      2:       return 64'(prd2);
      3:       return 64'(prd3);
      default: return prd4;
    endcase
  endfunction

  function automatic int dw_of(input int k);
    case (k)
      3:       return 8;
      4:       return 64;
      default: return 32;
    endcase
  endfunction

  function automatic int wait_of(input int k);
    case (k)
      0:       return 0;
      1:       return 3;
      2:       return 4;
      3:       return 1;
      default: return 2;
    endcase
  endfunction

  function automatic bit eom_of(input int k);
    return (k != 1);
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference memory for the random traffic: byte-lane updates, error decode
  // from address arithmetic.
  function automatic void predict(input int k, input logic wr, input logic [31:0] addr,
                                  input logic [63:0] wd, input logic [7:0] st,
                                  output logic [63:0] rd, output logic err);
    int unsigned bytes = dw_of(k) / 8;
    int unsigned idx   = addr / bytes;
    bit          mis   = eom_of(k) && ((addr % bytes) != 0);
    err = (idx >= 256) || mis;
    rd  = '0;
    if (!err) begin
      if (wr) begin
        for (int b = 0; b < int'(bytes); b++) begin
          if (st[b]) mdl[k][idx][8*b +: 8] = wd[8*b +: 8];
        end
      end else begin
        rd = mdl[k][idx];
      end
    end
  endfunction

  task automatic idle();
    psel    = '0;
    penable = 1'b0;
  endtask

  task automatic drive_setup(input int k, input logic wr, input logic [31:0] addr,
                             input logic [63:0] wd, input logic [7:0] st);
    psel    = '0;
    psel[k] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wd;
    pstrb   = st;
  endtask

  // Called at a negedge; returns at the negedge after the completing edge with
  // the bus still driven, so a following call forms a back-to-back transfer.
  task automatic xfer(input int k, input logic wr, input logic [31:0] addr,
                      input logic [63:0] wd, input logic [7:0] st,
                      input logic [63:0] exp_rd, input logic exp_err, input int exp_waits);
    sb_t it;
    int  waits;
    drive_setup(k, wr, addr, wd, st);
    sb.push_back('{k, exp_rd, exp_err, exp_waits});
    @(negedge PCLK);
    penable = 1'b1;
    waits   = 0;
    while (!pready[k] && waits < 40) begin
      @(negedge PCLK);
      waits++;
    end
    it = sb.pop_front();
    if (!pready[k]) begin
      n_checks++;
      n_fail++;
      $display("FAIL pready_timeout inst=%0d got=0 exp=1", k);
    end else begin
      chk($sformatf("prdata[%0d]@%h", it.k, addr), prd(it.k), it.rd);
      chk($sformatf("pslverr[%0d]@%h", it.k, addr), 64'(pslverr[it.k]), 64'(it.err));
      chk($sformatf("waits[%0d]@%h", it.k, addr), 64'(waits), 64'(it.waits));
      @(negedge PCLK);
      chk($sformatf("ready_one_cycle[%0d]", k), 64'(pready[k]), 64'd0);
    end
  endtask

  task automatic add(input int k, input logic wr, input logic [31:0] addr, input logic [63:0] wd,
                     input logic [7:0] st, input logic [63:0] rd, input logic err);
    tbl.push_back('{k, wr, addr, wd, st, rd, err, wait_of(k)});
  endtask

  task automatic run_random(input int k);
    int unsigned bytes = dw_of(k) / 8;
    logic [63:0] erd;
    logic        eerr;
    logic [63:0] wd;
    logic [7:0]  st;
    logic [31:0] addr;
    logic        wr;
    int          r;
    int unsigned idx;
    for (int i = 0; i < 8; i++) begin
      wd = {$urandom, $urandom};
      st = (bytes == 8) ? 8'hFF : 8'h01;
      predict(k, 1'b1, 32'(i) * bytes, wd, st, erd, eerr);
      xfer(k, 1'b1, 32'(i) * bytes, wd, st, erd, eerr, wait_of(k));
    end
    for (int i = 0; i < 16; i++) begin
      r    = $urandom_range(0, 9);
      idx  = $urandom_range(0, 7);
      wr   = 1'($urandom_range(0, 1));
      wd   = {$urandom, $urandom};
      st   = 8'($urandom_range(0, 255));
      addr = 32'(idx * bytes);
      if (r == 0) addr = 32'h0000_1000 + addr;
      else if (r == 1 && bytes > 1) addr = addr + 32'd3;
      predict(k, wr, addr, wd, st, erd, eerr);
      xfer(k, wr, addr, wd, st, erd, eerr, wait_of(k));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int seen;
    for (int k = 0; k < 5; k++)
      for (int j = 0; j < 256; j++) mdl[k][j] = '0;

    rst_n = 1'b0;
    idle();
    pwrite = 1'b0; paddr = '0; pwdata = '0; pstrb = '0;
    repeat (3) @(negedge PCLK);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("reset_pready[%0d]", k), 64'(pready[k]), 64'd0);
      chk($sformatf("reset_pslverr[%0d]", k), 64'(pslverr[k]), 64'd0);
      chk($sformatf("reset_prdata[%0d]", k), prd(k), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge PCLK);

    // k: 0 = 32b/0 wait, 1 = 32b/3 wait/no misalign err, 2 = 32b/4 wait
    add(0, 1, 32'h010, 64'hDEADBEEF, 8'hF, 64'h0,        0);
    add(0, 0, 32'h010, 64'h0,        8'h0, 64'hDEADBEEF, 0);
    add(0, 1, 32'h020, 64'h11223344, 8'hF, 64'h0,        0);
    add(0, 1, 32'h020, 64'hAABBCCDD, 8'h5, 64'h0,        0);
    add(0, 0, 32'h020, 64'h0,        8'hF, 64'h11BB33DD, 0);
    add(0, 1, 32'h020, 64'hFFFFFFFF, 8'h0, 64'h0,        0);
    add(0, 0, 32'h020, 64'h0,        8'h0, 64'h11BB33DD, 0);
    add(0, 0, 32'h400, 64'h0,        8'h0, 64'h0,        1);
    add(0, 1, 32'h012, 64'h12345678, 8'hF, 64'h0,        1);
    add(0, 0, 32'h010, 64'h0,        8'h0, 64'hDEADBEEF, 0);
    add(0, 0, 32'h013, 64'h0,        8'h0, 64'h0,        1);
    add(0, 1, 32'h3FC, 64'h0BADF00D, 8'hF, 64'h0,        0);
    add(0, 0, 32'h3FC, 64'h0,        8'h0, 64'h0BADF00D, 0);
    add(0, 1, 32'h400, 64'h55555555, 8'hF, 64'h0,        1);
    add(0, 1, 32'hFFFFFFFC, 64'h66666666, 8'hF, 64'h0,   1);
    add(0, 0, 32'h3FC, 64'h0,        8'h0, 64'h0BADF00D, 0);
    add(1, 1, 32'h010, 64'hCAFEBABE, 8'hF, 64'h0,        0);
    add(1, 0, 32'h010, 64'h0,        8'h0, 64'hCAFEBABE, 0);
    add(1, 1, 32'h012, 64'h01020304, 8'hF, 64'h0,        0);
    add(1, 0, 32'h010, 64'h0,        8'h0, 64'h01020304, 0);
    add(1, 0, 32'h011, 64'h0,        8'h0, 64'h01020304, 0);
    add(1, 0, 32'h400, 64'h0,        8'h0, 64'h0,        1);
    add(2, 1, 32'h040, 64'h55AA55AA, 8'hF, 64'h0,        0);
    add(2, 0, 32'h040, 64'h0,        8'h0, 64'h55AA55AA, 0);
    for (int i = 0; i < tbl.size(); i++)
      xfer(tbl[i].k, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].st, tbl[i].rd, tbl[i].err, tbl[i].waits);
    idle();
    @(negedge PCLK);

    // Abort: PSEL dropped in the second wait cycle
    drive_setup(2, 1'b1, 32'h040, 64'h12345678, 8'hF);
    @(negedge PCLK); penable = 1'b1;
    @(negedge PCLK); idle();
    seen = 0;
    repeat (8) begin
      @(negedge PCLK);
      if (pready[2]) seen = 1;
    end
    chk("abort_no_ready", 64'(seen), 64'd0);
    xfer(2, 1'b0, 32'h040, 64'h0, 8'h0, 64'h55AA55AA, 1'b0, 4);
    idle();

    // Reset asserted mid-wait
    drive_setup(2, 1'b1, 32'h040, 64'h99999999, 8'hF);
    @(negedge PCLK); penable = 1'b1;
    @(negedge PCLK);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wait_pready", 64'(pready[2]), 64'd0);
    chk("rst_wait_pslverr", 64'(pslverr[2]), 64'd0);
    @(negedge PCLK); idle(); rst_n = 1'b1;
    @(negedge PCLK);
    xfer(2, 1'b0, 32'h040, 64'h0, 8'h0, 64'h55AA55AA, 1'b0, 4);
    idle();

    // Reset while a read response is presented: outputs clear asynchronously
    drive_setup(0, 1'b0, 32'h3FC, 64'h0, 8'h0);
    @(negedge PCLK); penable = 1'b1;
    chk("resp_pready", 64'(pready[0]), 64'd1);
    chk("resp_prdata", prd(0), 64'h0BADF00D);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_resp_pready", 64'(pready[0]), 64'd0);
    chk("rst_resp_prdata", prd(0), 64'd0);
    @(negedge PCLK); idle(); rst_n = 1'b1;
    @(negedge PCLK);

    // Reset across the completing edge of a write: write discarded
    drive_setup(0, 1'b1, 32'h010, 64'h77777777, 8'hF);
    @(negedge PCLK); penable = 1'b1;
    chk("resp_wr_pready", 64'(pready[0]), 64'd1);
    #2 rst_n = 1'b0;
    @(negedge PCLK); idle(); rst_n = 1'b1;
    @(negedge PCLK);
    xfer(0, 1'b0, 32'h010, 64'h0, 8'h0, 64'hDEADBEEF, 1'b0, 0);
    idle();
    @(negedge PCLK);

    run_random(3);
    idle();
    @(negedge PCLK);
    run_random(4);
    idle();
    @(negedge PCLK);

    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
